// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS main controller sequencing fetch/decode/execute/memory/writeback.
// Build option MC_ILLEGAL_OP_TRAP_EN: unrecognised opcodes park in TRAP instead of retiring as a NOP.
module mc_control_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       Op_i,
  input  logic             mem_ready_i,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic [1:0]       PCSrc_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic             RegDst_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             trap_o
);

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_START;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  if (mem_ready_i) w_next = S_DECODE;
      S_DECODE: begin
        case (Op_i)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
`ifdef MC_ILLEGAL_OP_TRAP_EN
            w_next = S_TRAP;
`else
            // PC+4 already happened in FETCH, so retiring straight away is a NOP
            w_next   = S_FETCH;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: w_next = (Op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready_i) w_next = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready_i) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXEC_R: w_next = S_WB_R;
      S_EXEC_I: w_next = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_START;
    endcase
  end

  always_comb begin
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    IorD_o        = 1'b0;
    IRWrite_o     = 1'b0;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSrc_o       = 2'b00;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    RegDst_o      = 1'b0;
    MemtoReg_o    = 1'b0;
    RegWrite_o    = 1'b0;
    trap_o        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read_o = 1'b1;
        ALUSrcB_o  = 2'b01;
        IRWrite_o  = mem_ready_i;
        PCWrite_o  = mem_ready_i;
      end
      S_DECODE:   ALUSrcB_o = 2'b11;
      S_MEM_ADDR, S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        IorD_o      = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b10;
      end
      S_WB_R: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
      end
      S_WB_I:     RegWrite_o = 1'b1;
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        PCSrc_o       = 2'b01;
      end
      S_JUMP: begin
        PCWrite_o = 1'b1;
        PCSrc_o   = 2'b10;
      end
`ifdef MC_ILLEGAL_OP_TRAP_EN
      S_TRAP:     trap_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o     = r_state;
  assign instr_cnt_o = r_cnt;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-instruction control signatures predicted from opcode and wait counts.
module tb_mc_control_fsm;
  localparam int unsigned CNT_W = 4;
  localparam int NSIG = 17;
  localparam int TRAP_HOLD = 12;
  localparam int K_INSTR = 0, K_RESET = 1, K_TRAP = 2;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ILL = 6'h3F;

  logic clk = 1'b0;
  logic rst, rdy;
  logic [5:0] op;
  logic mem_read_o, mem_write_o, IorD_o, IRWrite_o, PCWrite_o, PCWriteCond_o;
  logic [1:0] PCSrc_o, ALUSrcB_o, ALUOp_o;
  logic ALUSrcA_o, RegDst_o, MemtoReg_o, RegWrite_o, trap_o;
  logic [3:0] state_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic [15:0] w_outs;

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .Op_i(op), .mem_ready_i(rdy),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .IorD_o(IorD_o),
    .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o),
    .PCSrc_o(PCSrc_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .state_o(state_o), .instr_cnt_o(instr_cnt_o), .trap_o(trap_o)
  );

  assign w_outs = {mem_read_o, mem_write_o, IorD_o, IRWrite_o, PCWrite_o, PCWriteCond_o,
                   PCSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegDst_o, MemtoReg_o, RegWrite_o};

  int checks = 0, errors = 0;
  int model_cnt = 0;
  int q_kind[$], q_cnt[$], q_sig[$];
  int e_kind, e_cnt;
  int e_sig[NSIG];
  string signame[NSIG] = '{"cycles", "mem_read_cyc", "mem_write_cyc", "IorD_cyc", "IRWrite_cyc",
                           "PCWrite_cyc", "PCWriteCond_cyc", "RegWrite_cyc", "RegDst_cyc",
                           "MemtoReg_cyc", "ALUSrcA_cyc", "ALUSrcB_sum", "ALUOp_sum", "PCSrc_sum",
                           "state_path", "rd_wr_overlap", "trap_cyc"};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_exp(input int kind, input int cnt, input int s[NSIG]);
    q_kind.push_back(kind);
    q_cnt.push_back(cnt);
    for (int i = 0; i < NSIG; i++) q_sig.push_back(s[i]);
  endtask

  task automatic take(input int want);
    if (q_kind.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
      e_kind = -1; e_cnt = -1;
      for (int i = 0; i < NSIG; i++) e_sig[i] = -1;
    end else begin
      e_kind = q_kind.pop_front();
      e_cnt  = q_cnt.pop_front();
      for (int i = 0; i < NSIG; i++) e_sig[i] = q_sig.pop_front();
      chk("event_kind", want, e_kind);
    end
  endtask

  // Reference: each instruction's cycle count and per-signal activity follow from its phase list.
  task automatic push_instr(input logic [5:0] o, input int fw, input int mw);
    int s[NSIG];
    for (int i = 0; i < NSIG; i++) s[i] = 0;
    s[0] = 2 + fw; s[1] = fw + 1; s[4] = 1; s[5] = 1; s[11] = (fw + 1) + 3; s[14] = 'h12;
    case (o)
      OP_R:    begin s[0] += 2; s[10] += 1; s[12] += 2; s[7] += 1; s[8] += 1; s[14] = 'h1278; end
      OP_ADDI: begin s[0] += 2; s[10] += 1; s[11] += 2; s[7] += 1; s[14] = 'h129A; end
      OP_LW:   begin s[0] += 3 + mw; s[10] += 1; s[11] += 2; s[1] += mw + 1; s[3] += mw + 1;
                     s[7] += 1; s[9] += 1; s[14] = 'h12345; end
      OP_SW:   begin s[0] += 2 + mw; s[10] += 1; s[11] += 2; s[2] += mw + 1; s[3] += mw + 1;
                     s[14] = 'h1236; end
      OP_BEQ:  begin s[0] += 1; s[10] += 1; s[12] += 1; s[6] += 1; s[13] += 1; s[14] = 'h12B; end
      OP_J:    begin s[0] += 1; s[5] += 1; s[13] += 2; s[14] = 'h12C; end
      default: ;
    endcase
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    push_exp(K_INSTR, model_cnt, s);
  endtask

  task automatic drive(input bit sched[$]);
    foreach (sched[i]) begin
      rdy = sched[i];
      @(posedge clk); #1;
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(1, 0));
  endfunction

  task automatic build(input logic [5:0] o, input int fw, input int mw, output bit sched[$]);
    sched = {};
    repeat (fw) sched.push_back(1'b0);
    sched.push_back(1'b1);
    sched.push_back(rb());
    case (o)
      OP_R, OP_ADDI: begin sched.push_back(rb()); sched.push_back(rb()); end
      OP_LW: begin sched.push_back(rb()); repeat (mw) sched.push_back(1'b0);
                   sched.push_back(1'b1); sched.push_back(rb()); end
      OP_SW: begin sched.push_back(rb()); repeat (mw) sched.push_back(1'b0); sched.push_back(1'b1); end
      OP_BEQ, OP_J: sched.push_back(rb());
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
    bit sched[$];
    build(o, fw, mw, sched);
    push_instr(o, fw, mw);
    op = o;
    drive(sched);
  endtask

  task automatic do_reset();
    int z[NSIG];
    for (int i = 0; i < NSIG; i++) z[i] = 0;
    push_exp(K_RESET, 0, z);
    model_cnt = 0;
    rst = 1'b1; rdy = rb();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // lw parked in MEM_RD when reset hits: the aborted instruction never retires.
  task automatic run_lw_abort();
    bit sched[$];
    sched = {1'b1, rb(), rb(), 1'b0, 1'b0, 1'b0};
    op = OP_LW;
    drive(sched);
    do_reset();
  endtask

  task automatic run_trap();
    int s[NSIG];
    for (int i = 0; i < NSIG; i++) s[i] = 0;
    s[0] = TRAP_HOLD + 1;
    push_exp(K_TRAP, model_cnt, s);
    op = OP_ILL; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = rb();
    @(posedge clk); #1;
    repeat (TRAP_HOLD) begin rdy = rb(); @(posedge clk); #1; end
  endtask

  initial begin : monitor
    int st, prev, tgood, thold, tcnt;
    bit active, in_trap;
    int acc[NSIG];
    prev = -1; active = 0; in_trap = 0; tgood = 0; thold = 0; tcnt = 0;
    for (int i = 0; i < NSIG; i++) acc[i] = 0;
    forever begin
      @(negedge clk);
      st = int'(state_o);
      if (st == 0 && prev != 0) begin
        if (in_trap) begin chk("trap_hold_cycles", tgood, thold); in_trap = 0; end
        take(K_RESET);
        chk("reset_outputs", int'(w_outs), 0);
        chk("reset_instr_cnt", int'(instr_cnt_o), e_cnt);
        chk("reset_trap", int'(trap_o), 0);
        active = 0;
      end else if (st == 13 && prev != 13) begin
        take(K_TRAP);
        active = 0; in_trap = 1; tgood = 0; thold = e_sig[0]; tcnt = e_cnt;
      end else if (st == 1 && prev != 1) begin
        if (active) begin
          take(K_INSTR);
          for (int i = 0; i < NSIG; i++) chk(signame[i], acc[i], e_sig[i]);
          chk("instr_cnt", int'(instr_cnt_o), e_cnt);
        end
        active = 1;
        for (int i = 0; i < NSIG; i++) acc[i] = 0;
        acc[14] = 1;
      end else if (active && st != prev) begin
        acc[14] = acc[14] * 16 + st;
      end
      if (in_trap && st == 13 && trap_o === 1'b1 && w_outs == '0 && int'(instr_cnt_o) == tcnt) tgood++;
      if (active) begin
        acc[0]++;
        acc[1] += int'(mem_read_o);   acc[2] += int'(mem_write_o);  acc[3] += int'(IorD_o);
        acc[4] += int'(IRWrite_o);    acc[5] += int'(PCWrite_o);    acc[6] += int'(PCWriteCond_o);
        acc[7] += int'(RegWrite_o);   acc[8] += int'(RegDst_o);     acc[9] += int'(MemtoReg_o);
        acc[10] += int'(ALUSrcA_o);   acc[11] += int'(ALUSrcB_o);   acc[12] += int'(ALUOp_o);
        acc[13] += int'(PCSrc_o);     acc[15] += int'(mem_read_o & mem_write_o);
        acc[16] += int'(trap_o);
      end
      prev = st;
    end
  end

  initial begin : stimulus
    logic [5:0] ops[7];
    int nops;
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ILL};
`ifdef MC_ILLEGAL_OP_TRAP_EN
    nops = 6;
`else
    nops = 7;
`endif
    rst = 1'b1; rdy = 1'b0; op = OP_R;
    do_reset();
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_lw_abort();
    repeat (17) run_instr(OP_ADDI, 0, 0);
    repeat (80) run_instr(ops[$urandom_range(nops - 1, 0)], $urandom_range(2, 0), $urandom_range(3, 0));
`ifdef MC_ILLEGAL_OP_TRAP_EN
    run_trap();
    do_reset();
    run_instr(OP_R, 1, 0);
`else
    run_instr(OP_ILL, 0, 0);
    run_instr(OP_ILL, 2, 0);
`endif
    rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", q_kind.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
